// File: rtl/signed_cmp_tracker.sv
// signed_cmp_tracker: registered signed/unsigned comparator with running max/min of
// operand a and a saturating sample counter. Rev 1.0
`default_nettype none

module signed_cmp_tracker #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clear,
  output logic             out_valid,
  output logic             gt,
  output logic             lt,
  output logic             eq,
  output logic [WIDTH-1:0] run_max,
  output logic [WIDTH-1:0] run_min,
  output logic             have_data,
  output logic [CNT_W-1:0] count,
  output logic             count_sat
);

  // Flipping the MSB maps two's-complement order onto unsigned order.
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_a_k;
  logic [WIDTH-1:0] w_b_k;
  logic [WIDTH-1:0] w_max_k;
  logic [WIDTH-1:0] w_min_k;

  logic             out_valid_q, gt_q, lt_q, eq_q;
  logic [WIDTH-1:0] run_max_q, run_max_d;
  logic [WIDTH-1:0] run_min_q, run_min_d;
  logic             have_data_q, have_data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             count_sat_q, count_sat_d;

  assign w_mask  = {signed_mode, {(WIDTH-1){1'b0}}};
  assign w_a_k   = a ^ w_mask;
  assign w_b_k   = b ^ w_mask;
  assign w_max_k = run_max_q ^ w_mask;
  assign w_min_k = run_min_q ^ w_mask;

  always_comb begin
    run_max_d   = run_max_q;
    run_min_d   = run_min_q;
    have_data_d = have_data_q;
    count_d     = count_q;
    if (clear) begin
      run_max_d   = '0;
      run_min_d   = '0;
      have_data_d = 1'b0;
      count_d     = '0;
    end
    if (in_valid) begin
      if (clear || !have_data_q) begin
        run_max_d   = a;
        run_min_d   = a;
        have_data_d = 1'b1;
        count_d     = {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        if (w_a_k > w_max_k) run_max_d = a;
        if (w_a_k < w_min_k) run_min_d = a;
        if (!count_sat_q) count_d = count_q + 1'b1;
      end
    end
    count_sat_d = &count_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      gt_q        <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      run_max_q   <= '0;
      run_min_q   <= '0;
      have_data_q <= 1'b0;
      count_q     <= '0;
      count_sat_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        gt_q <= (w_a_k > w_b_k);
        lt_q <= (w_a_k < w_b_k);
        eq_q <= (a == b);
      end
      run_max_q   <= run_max_d;
      run_min_q   <= run_min_d;
      have_data_q <= have_data_d;
      count_q     <= count_d;
      count_sat_q <= count_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign gt        = gt_q;
  assign lt        = lt_q;
  assign eq        = eq_q;
  assign run_max   = run_max_q;
  assign run_min   = run_min_q;
  assign have_data = have_data_q;
  assign count     = count_q;
  assign count_sat = count_sat_q;

endmodule

`default_nettype wire

// File: tb/tb_signed_cmp_tracker.sv
// Directed bench for signed_cmp_tracker: WIDTH=4 instance plus a CNT_W=2 instance
// for counter saturation.
`default_nettype none

module tb_signed_cmp_tracker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0, signed_mode = 1'b0, clear = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic       out_valid, gt, lt, eq, have_data, count_sat;
  logic [3:0] run_max, run_min;
  logic [7:0] count;

  logic       in_valid2 = 1'b0;
  logic [3:0] a2 = '0;
  logic       out_valid2, gt2, lt2, eq2, have_data2, count_sat2;
  logic [3:0] run_max2, run_min2;
  logic [1:0] count2;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  signed_cmp_tracker #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .signed_mode(signed_mode),
    .a(a), .b(b), .clear(clear), .out_valid(out_valid), .gt(gt), .lt(lt), .eq(eq),
    .run_max(run_max), .run_min(run_min), .have_data(have_data), .count(count),
    .count_sat(count_sat)
  );

  signed_cmp_tracker #(.WIDTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .signed_mode(1'b0),
    .a(a2), .b(4'd0), .clear(1'b0), .out_valid(out_valid2), .gt(gt2), .lt(lt2),
    .eq(eq2), .run_max(run_max2), .run_min(run_min2), .have_data(have_data2),
    .count(count2), .count_sat(count_sat2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flags(input string tag, input logic ov, input logic g, input logic l, input logic e);
    check({tag, ".ov"}, {31'd0, out_valid}, {31'd0, ov});
    check({tag, ".gt"}, {31'd0, gt}, {31'd0, g});
    check({tag, ".lt"}, {31'd0, lt}, {31'd0, l});
    check({tag, ".eq"}, {31'd0, eq}, {31'd0, e});
  endtask

  task automatic track(input string tag, input logic [3:0] mx, input logic [3:0] mn,
                       input logic hd, input logic [7:0] cnt);
    check({tag, ".max"}, {28'd0, run_max}, {28'd0, mx});
    check({tag, ".min"}, {28'd0, run_min}, {28'd0, mn});
    check({tag, ".have"}, {31'd0, have_data}, {31'd0, hd});
    check({tag, ".cnt"}, {24'd0, count}, {24'd0, cnt});
    check({tag, ".sat"}, {31'd0, count_sat}, {31'd0, 1'b0});
  endtask

  task automatic sample(input logic sm, input logic [3:0] va, input logic [3:0] vb);
    in_valid = 1'b1; signed_mode = sm; a = va; b = vb;
  endtask

  initial begin
    // Reset state
    #12;
    flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    track("rst", 4'd0, 4'd0, 1'b0, 8'd0);
    check("rst2.cnt", {30'd0, count2}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Test 1: 1000 vs 0111 signed then unsigned
    sample(1'b1, 4'b1000, 4'b0111);
    step();
    flags("t1s", 1'b1, 1'b0, 1'b1, 1'b0);
    track("t1s", 4'b1000, 4'b1000, 1'b1, 8'd1);
    sample(1'b0, 4'b1000, 4'b0111);
    step();
    flags("t1u", 1'b1, 1'b1, 1'b0, 1'b0);
    track("t1u", 4'b1000, 4'b1000, 1'b1, 8'd2);

    // Test 2: equal operands in both modes, then idle hold
    sample(1'b1, 4'hF, 4'hF);
    step();
    flags("t2s", 1'b1, 1'b0, 1'b0, 1'b1);
    track("t2s", 4'hF, 4'b1000, 1'b1, 8'd3);   // -1 > -8 signed
    sample(1'b0, 4'hF, 4'hF);
    step();
    flags("t2u", 1'b1, 1'b0, 1'b0, 1'b1);
    track("t2u", 4'hF, 4'b1000, 1'b1, 8'd4);
    in_valid = 1'b0;
    step();
    flags("t2idle", 1'b0, 1'b0, 1'b0, 1'b1);
    track("t2idle", 4'hF, 4'b1000, 1'b1, 8'd4);

    // Clear alone before the signed stream
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr0.ov", {31'd0, out_valid}, 32'd0);
    track("clr0", 4'd0, 4'd0, 1'b0, 8'd0);

    // Test 3: signed stream 3, -2, 7, -8, 0 against b=0
    sample(1'b1, 4'd3, 4'd0);    step(); flags("t3a", 1'b1, 1'b1, 1'b0, 1'b0);
    sample(1'b1, 4'b1110, 4'd0); step(); flags("t3b", 1'b1, 1'b0, 1'b1, 1'b0);
    sample(1'b1, 4'd7, 4'd0);    step(); flags("t3c", 1'b1, 1'b1, 1'b0, 1'b0);
    sample(1'b1, 4'b1000, 4'd0); step(); flags("t3d", 1'b1, 1'b0, 1'b1, 1'b0);
    sample(1'b1, 4'd0, 4'd0);    step(); flags("t3e", 1'b1, 1'b0, 1'b0, 1'b1);
    track("t3", 4'd7, 4'b1000, 1'b1, 8'd5);

    // Test 5: clear with a sample, then clear alone
    clear = 1'b1;
    sample(1'b1, 4'd2, 4'd2);
    step();
    flags("t5a", 1'b1, 1'b0, 1'b0, 1'b1);
    track("t5a", 4'd2, 4'd2, 1'b1, 8'd1);
    in_valid = 1'b0;
    step();
    clear = 1'b0;
    check("t5b.ov", {31'd0, out_valid}, 32'd0);
    track("t5b", 4'd0, 4'd0, 1'b0, 8'd0);

    // Test 4: CNT_W=2 saturation on the second instance
    in_valid2 = 1'b1; a2 = 4'd1;
    step(); check("t4.c1", {30'd0, count2}, 32'd1); check("t4.s1", {31'd0, count_sat2}, 32'd0);
    step(); check("t4.c2", {30'd0, count2}, 32'd2); check("t4.s2", {31'd0, count_sat2}, 32'd0);
    step(); check("t4.c3", {30'd0, count2}, 32'd3); check("t4.s3", {31'd0, count_sat2}, 32'd1);
    step(); check("t4.c4", {30'd0, count2}, 32'd3); check("t4.s4", {31'd0, count_sat2}, 32'd1);
    step(); check("t4.c5", {30'd0, count2}, 32'd3); check("t4.s5", {31'd0, count_sat2}, 32'd1);
    in_valid2 = 1'b0;

    // Test 6: asynchronous reset between edges mid-stream
    sample(1'b1, 4'd5, 4'd1);
    step();
    step();
    track("t6pre", 4'd5, 4'd5, 1'b1, 8'd2);
    #2;
    reset = 1'b0;
    #1;
    flags("t6rst", 1'b0, 1'b0, 1'b0, 1'b0);
    track("t6rst", 4'd0, 4'd0, 1'b0, 8'd0);
    check("t6rst2.cnt", {30'd0, count2}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    sample(1'b0, 4'd9, 4'd3);
    step();
    flags("t6post", 1'b1, 1'b1, 1'b0, 1'b0);
    track("t6post", 4'd9, 4'd9, 1'b1, 8'd1);
    in_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
